// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and 3-stage sequencer for the single-port data memory.
// Shares the memory between the core MEM stage and the DMA/debug loader.
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 32,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  output logic              core_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              dma_err,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_Write_data,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [31:0]       mem_Read_data
);

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(4 * DEPTH_WORDS);

  logic              last_owner;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_err;

  logic              acc_valid;
  logic              acc_owner;
  logic              acc_we;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_go;

  // Grant: lone requester wins; on contention the port that did not go last wins.
  always_comb begin
    core_gnt = rst_n & core_req &
               (~dma_req | (last_owner == OWN_DMA));
    dma_gnt  = rst_n & dma_req &
               (~core_req | (last_owner == OWN_CORE));
    any_gnt  = core_gnt | dma_gnt;
    sel_we    = core_gnt ? core_we    : dma_we;
    sel_addr  = core_gnt ? core_addr  : dma_addr;
    sel_wdata = core_gnt ? core_wdata : dma_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) | (sel_addr >= LIMIT);
  end

  // Accept stage: register the granted request; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_DMA;
      acc_valid  <= 1'b0;
      acc_owner  <= OWN_CORE;
      acc_we     <= 1'b0;
      acc_err    <= 1'b0;
      acc_addr   <= '0;
      acc_wdata  <= '0;
    end else begin
      acc_valid <= any_gnt;
      if (any_gnt) begin
        last_owner <= dma_gnt ? OWN_DMA : OWN_CORE;
        acc_owner  <= dma_gnt ? OWN_DMA : OWN_CORE;
        acc_we     <= sel_we;
        acc_err    <= sel_err;
        acc_addr   <= sel_addr;
        acc_wdata  <= sel_wdata;
      end
    end
  end

  // Access stage: strobes come only from registers, so reset kills them at once.
  always_comb begin
    acc_go         = acc_valid & ~acc_err;
    mem_MemRead    = acc_go & ~acc_we;
    mem_MemWrite   = acc_go & acc_we;
    mem_address    = 32'(acc_addr);
    mem_Write_data = acc_wdata;
  end

  // Response stage: one-cycle pulse routed back to the owner of the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      core_err    <= 1'b0;
      dma_rvalid  <= 1'b0;
      dma_rdata   <= '0;
      dma_err     <= 1'b0;
    end else begin
      core_rvalid <= acc_valid & (acc_owner == OWN_CORE);
      core_err    <= acc_valid & (acc_owner == OWN_CORE) & acc_err;
      core_rdata  <= (mem_MemRead & (acc_owner == OWN_CORE)) ?
                     mem_Read_data : 32'h0;
      dma_rvalid  <= acc_valid & (acc_owner == OWN_DMA);
      dma_err     <= acc_valid & (acc_owner == OWN_DMA) & acc_err;
      dma_rdata   <= (mem_MemRead & (acc_owner == OWN_DMA)) ?
                     mem_Read_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a request-level model of arbitration and memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 0, core_we = 0;
  logic [31:0] core_addr = 0, core_wdata = 0;
  logic        core_gnt, core_rvalid, core_err;
  logic [31:0] core_rdata;
  logic        dma_req = 0, dma_we = 0;
  logic [31:0] dma_addr = 0, dma_wdata = 0;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic [31:0] dma_rdata;
  logic [31:0] mem_address, mem_Write_data;
  logic        mem_MemRead, mem_MemWrite;
  logic [31:0] mem_Read_data = 0;

  int total = 0;
  int bad = 0;

  logic        o_cgnt, o_dgnt, o_rd, o_wr;
  logic [31:0] tmem [0:31];
  logic [31:0] rmem [0:31];
  logic        pl_en = 0, tclr = 0;
  logic [4:0]  pl_idx = 0;
  logic [31:0] pl_val = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH_WORDS(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .core_err(core_err),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_address(mem_address), .mem_Write_data(mem_Write_data),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_Read_data(mem_Read_data)
  );

  // Memory: writes on posedge, read data refreshed on negedge.
  always @(posedge clk) begin
    if (tclr) begin
      for (int i = 0; i < 32; i++) tmem[i] <= 32'h0;
    end else if (pl_en) begin
      tmem[pl_idx] <= pl_val;
    end else if (mem_MemWrite) begin
      tmem[mem_address[6:2]] <= mem_Write_data;
    end
  end

  always @(negedge clk) mem_Read_data <= tmem[mem_address[6:2]];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mem();
    tclr = 1; tick(); tclr = 0;
    for (int i = 0; i < 32; i++) rmem[i] = 32'h0;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pl_en = 1; pl_idx = 5'(idx); pl_val = val;
    tick();
    pl_en = 0;
    rmem[idx] = val;
  endtask

  task automatic do_reset();
    core_req = 0; dma_req = 0;
    rst_n = 0; tick(); tick();
    rst_n = 1;
  endtask

  task automatic cyc(input logic creq, input logic cwe,
                     input logic [31:0] ca, input logic [31:0] cd,
                     input logic dreq, input logic dwe,
                     input logic [31:0] da, input logic [31:0] dd);
    core_req = creq; core_we = cwe; core_addr = ca; core_wdata = cd;
    dma_req = dreq; dma_we = dwe; dma_addr = da; dma_wdata = dd;
    @(negedge clk);
    o_cgnt = core_gnt; o_dgnt = dma_gnt;
    o_rd = mem_MemRead; o_wr = mem_MemWrite;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 12) return 32'($urandom_range(0, 31) * 4);
    if (r < 14) return 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
    return 32'($urandom_range(32, 40) * 4);
  endfunction

  task automatic test_reset();
    core_req = 1; dma_req = 1;
    rst_n = 0; #1;
    total++;
    if ({core_gnt, dma_gnt} !== 2'b00) begin
      bad++; $display("FAIL reset_gnt got=%b want=00", {core_gnt, dma_gnt});
    end
    total++;
    if ({core_rvalid, dma_rvalid, core_err, dma_err,
         mem_MemRead, mem_MemWrite} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0", {core_rvalid,
        dma_rvalid, core_err, dma_err, mem_MemRead, mem_MemWrite});
    end
    total++;
    if ({core_rdata, dma_rdata, mem_address, mem_Write_data} !== 128'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0",
        {core_rdata, dma_rdata, mem_address, mem_Write_data});
    end
    do_reset();
  endtask

  task automatic test_raw();
    do_reset();
    cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    total++;
    if (o_cgnt !== 1'b1) begin
      bad++; $display("FAIL raw_gnt got=%b want=1", o_cgnt);
    end
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0);
    total++;
    if ({o_wr, o_rd} !== 2'b10) begin
      bad++; $display("FAIL raw_wstrobe got=%b want=10", {o_wr, o_rd});
    end
    total++;
    if ({core_rvalid, core_err, core_rdata, dma_rvalid} !== {2'b10, 32'h0, 1'b0}) begin
      bad++; $display("FAIL raw_wresp got=%b/%b/%h/%b want=1/0/0/0",
        core_rvalid, core_err, core_rdata, dma_rvalid);
    end
    idle();
    total++;
    if ({core_rvalid, core_err, core_rdata, dma_rvalid} !==
        {2'b10, 32'hDEADBEEF, 1'b0}) begin
      bad++; $display("FAIL raw_rresp got=%b/%b/%h/%b want=1/0/deadbeef/0",
        core_rvalid, core_err, core_rdata, dma_rvalid);
    end
    rmem[4] = 32'hDEADBEEF;
    idle();
    total++;
    if ({core_rvalid, dma_rvalid} !== 2'b00) begin
      bad++; $display("FAIL raw_quiet got=%b want=00", {core_rvalid, dma_rvalid});
    end
  endtask

  task automatic test_fairness();
    int ci, di, j;
    logic ec;
    do_reset();
    for (int i = 0; i < 6; i++) preload(8 + i, 32'(100 + 8 + i));
    ci = 0; di = 0;
    for (int k = 0; k < 7; k++) begin
      cyc(ci < 3, 0, 32'((8 + 2 * ci) * 4), 0,
          di < 3, 0, 32'((9 + 2 * di) * 4), 0);
      ec = (k < 6) && (k % 2 == 0);
      total++;
      if ({o_cgnt, o_dgnt} !== {ec, (k < 6) && !ec}) begin
        bad++; $display("FAIL rr_gnt k=%0d got=%b want=%b", k,
          {o_cgnt, o_dgnt}, {ec, (k < 6) && !ec});
      end
      if (o_cgnt) ci++;
      if (o_dgnt) di++;
      if (k >= 1) begin
        j = k - 1;
        total++;
        if ({core_rvalid, dma_rvalid} !== {j % 2 == 0, j % 2 == 1}) begin
          bad++; $display("FAIL rr_route j=%0d got=%b", j,
            {core_rvalid, dma_rvalid});
        end
        total++;
        if ((j % 2 == 0 ? core_rdata : dma_rdata) !== 32'(108 + j)) begin
          bad++; $display("FAIL rr_data j=%0d got=%0d want=%0d", j,
            (j % 2 == 0 ? core_rdata : dma_rdata), 108 + j);
        end
      end
    end
  endtask

  task automatic test_error();
    cyc(0, 0, 0, 0, 1, 0, 32'h06, 0);
    total++;
    if (o_dgnt !== 1'b1) begin
      bad++; $display("FAIL err_gnt got=%b want=1", o_dgnt);
    end
    idle();
    total++;
    if ({o_rd, o_wr} !== 2'b00) begin
      bad++; $display("FAIL err_strobe got=%b want=00", {o_rd, o_wr});
    end
    total++;
    if ({dma_rvalid, dma_err, dma_rdata, core_rvalid} !== {2'b11, 32'h0, 1'b0}) begin
      bad++; $display("FAIL err_resp got=%b/%b/%h/%b want=1/1/0/0",
        dma_rvalid, dma_err, dma_rdata, core_rvalid);
    end
    preload(0, 32'hA5A5_0F0F);
    cyc(1, 1, 32'h80, 32'h1111_2222, 0, 0, 0, 0);
    idle();
    total++;
    if (o_wr !== 1'b0) begin
      bad++; $display("FAIL oob_strobe got=%b want=0", o_wr);
    end
    total++;
    if ({core_rvalid, core_err} !== 2'b11) begin
      bad++; $display("FAIL oob_resp got=%b want=11", {core_rvalid, core_err});
    end
    cyc(1, 0, 32'h0, 0, 0, 0, 0, 0);
    idle();
    total++;
    if (core_rdata !== rmem[0]) begin
      bad++; $display("FAIL oob_keep got=%h want=%h", core_rdata, rmem[0]);
    end
  endtask

  task automatic test_reset_mid();
    preload(1, 32'h0000_0055);
    cyc(1, 1, 32'h04, 32'h1234, 0, 0, 0, 0);
    core_req = 0;
    @(negedge clk);
    total++;
    if (mem_MemWrite !== 1'b1) begin
      bad++; $display("FAIL mid_pre got=%b want=1", mem_MemWrite);
    end
    #1 rst_n = 0;
    #1;
    total++;
    if (mem_MemWrite !== 1'b0) begin
      bad++; $display("FAIL mid_drop got=%b want=0", mem_MemWrite);
    end
    tick();
    tick();
    rst_n = 1;
    idle();
    total++;
    if ({core_rvalid, dma_rvalid} !== 2'b00) begin
      bad++; $display("FAIL mid_noresp got=%b want=00", {core_rvalid, dma_rvalid});
    end
    cyc(1, 0, 32'h04, 0, 0, 0, 0, 0);
    idle();
    total++;
    if ({core_rvalid, core_rdata} !== {1'b1, rmem[1]}) begin
      bad++; $display("FAIL mid_keep got=%b/%h want=1/%h",
        core_rvalid, core_rdata, rmem[1]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) preload(i, 32'(i + 1));
    for (int k = 0; k < 6; k++) begin
      cyc(k < 4, 0, 32'(k * 4), 0, 0, 0, 0, 0);
      if (k >= 1 && k <= 4) begin
        total++;
        if ({core_rvalid, core_rdata} !== {1'b1, 32'(k)}) begin
          bad++; $display("FAIL b2b k=%0d got=%b/%0d want=1/%0d",
            k, core_rvalid, core_rdata, k);
        end
      end
    end
    total++;
    if (core_rvalid !== 1'b0) begin
      bad++; $display("FAIL b2b_end got=%b want=0", core_rvalid);
    end
  endtask

  task automatic test_random();
    logic c_p, c_w, d_p, d_w, ec, ed, last_dma;
    logic [31:0] c_a, c_d, d_a, d_d, a;
    logic p_v, p_dma, p_we, p_err, n_err;
    logic [31:0] p_data;
    do_reset();
    clear_mem();
    last_dma = 1; p_v = 0; p_dma = 0; p_we = 0; p_err = 0; p_data = 0;
    c_p = 0; d_p = 0; c_w = 0; d_w = 0; c_a = 0; d_a = 0; c_d = 0; d_d = 0;
    for (int n = 0; n < 300; n++) begin
      if (!c_p) begin
        c_p = $urandom_range(0, 9) < 7; c_w = 1'($urandom);
        c_a = rand_addr(); c_d = $urandom;
      end
      if (!d_p) begin
        d_p = $urandom_range(0, 9) < 7; d_w = 1'($urandom);
        d_a = rand_addr(); d_d = $urandom;
      end
      ec = c_p && (!d_p || last_dma);
      ed = d_p && (!c_p || !last_dma);
      cyc(c_p, c_w, c_a, c_d, d_p, d_w, d_a, d_d);
      total++;
      if ({o_cgnt, o_dgnt} !== {ec, ed}) begin
        bad++; $display("FAIL rnd_gnt n=%0d got=%b want=%b", n,
          {o_cgnt, o_dgnt}, {ec, ed});
      end
      total++;
      if ({o_rd, o_wr} !== {p_v && !p_err && !p_we, p_v && !p_err && p_we}) begin
        bad++; $display("FAIL rnd_strobe n=%0d got=%b want=%b", n,
          {o_rd, o_wr}, {p_v && !p_err && !p_we, p_v && !p_err && p_we});
      end
      total++;
      if ({core_rvalid, dma_rvalid} !== {p_v && !p_dma, p_v && p_dma}) begin
        bad++; $display("FAIL rnd_route n=%0d got=%b want=%b", n,
          {core_rvalid, dma_rvalid}, {p_v && !p_dma, p_v && p_dma});
      end
      if (p_v) begin
        total++;
        if ((p_dma ? {dma_err, dma_rdata} : {core_err, core_rdata})
            !== {p_err, p_data}) begin
          bad++; $display("FAIL rnd_resp n=%0d got=%b/%h want=%b/%h", n,
            p_dma ? dma_err : core_err, p_dma ? dma_rdata : core_rdata,
            p_err, p_data);
        end
      end
      p_v = ec || ed;
      if (p_v) begin
        p_dma = ed;
        p_we = ed ? d_w : c_w;
        a = ed ? d_a : c_a;
        n_err = (a[1:0] != 0) || (a >= 32'd128);
        p_err = n_err;
        p_data = (!n_err && !p_we) ? rmem[a[6:2]] : 32'h0;
        if (!n_err && p_we) rmem[a[6:2]] = ed ? d_d : c_d;
        last_dma = ed;
        if (ec) c_p = 0;
        if (ed) d_p = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_fairness();
    test_error();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port pipelined arbiter and sequencer for the single-port data memory.
- Shares the memory between the core's MEM stage (core_*) and a DMA/debug loader (dma_*), with round-robin fairness.
- Drives the memory's address, write-data and read/write strobes, and captures read data.
- Returns a registered response (ack, data, error) to the requester that was granted.

Parameters:
DEPTH_WORDS, 32, number of 32-bit words in the data memory; valid byte addresses are 0 to 4*DEPTH_WORDS-1
ADDR_W, 32, byte-address width on all ports

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
core_req  in  1  core requests an access this cycle
core_we  in  1  1 = write, 0 = read
core_addr  in  ADDR_W  byte address
core_wdata  in  32  write data
core_gnt  out  1  combinational; request accepted this cycle
core_rvalid  out  1  registered one-cycle response pulse
core_rdata  out  32  read data, valid with core_rvalid
core_err  out  1  error flag, valid with core_rvalid
dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata, dma_err  same as core_* for the DMA port
mem_address  out  32  to memory address
mem_Write_data  out  32  to memory write data
mem_MemRead  out  1  to memory read enable
mem_MemWrite  out  1  to memory write enable
mem_Read_data  in  32  from memory; updated by the memory on negedge clk

Behaviour:
- Reset: clk is the only clock. rst_n is asynchronous and active-low.
  - All outputs, pipeline registers and valid bits clear to 0 immediately on rst_n low.
  - Round-robin pointer last_owner resets to DMA, so the core wins the first contention.
- Pipeline: three stages, throughput one access per cycle.
  - Cycle N (accept): grant is computed combinationally. Accepted {owner, we, addr, wdata, err} is registered into the access stage (acc_valid=1).
  - Cycle N+1 (access): if acc_valid and not err:
    - mem_address = acc_addr; mem_Write_data = acc_wdata.
    - mem_MemWrite = acc_we; mem_MemRead = !acc_we. Both strobes are driven from registers, never from request inputs.
    - The write commits at the posedge ending N+1. Read data appears at the negedge within N+1 and is sampled at the posedge ending N+1.
  - Cycle N+2 (response): owner's rvalid = 1 for exactly one cycle. Applies to reads, writes and errors.
    - rdata = sampled mem_Read_data for a successful read; 0 for writes and errors.
    - err = 1 if the access was flagged. The non-owner port's rvalid stays 0.
- Arbitration:
  - Only one requester: it is granted.
  - Both requesting: the port not equal to last_owner is granted. last_owner updates on every grant.
  - No request: no grant, acc_valid=0 next cycle, both strobes 0.
  - A requester holds req/we/addr/wdata stable until gnt. A gnt always accepts; there is no stall or backpressure.
- Error check (at accept):
  - err = (addr[1:0] != 0) or (addr >= 4*DEPTH_WORDS).
  - An errored access is accepted and responded to, but mem_MemRead and mem_MemWrite stay 0 in its access cycle.
- mem_address and mem_Write_data hold their last value when idle. Only the strobes are meaningful.
- Read-after-write:
  - Write accepted in N, read of the same address accepted in N+1: the read returns the new data, since the write commits before the read's negedge.
  - No forwarding logic is required.
- Reset mid-operation:
  - In-flight accesses are discarded and no response is issued.
  - mem_MemWrite falls asynchronously, so a write whose access cycle is cut by reset does not commit.

Test Plan:
- Core write 0x10=0xDEADBEEF in cycle 0, core read 0x10 in cycle 1 -> core_rvalid in cycle 2 (err=0, rdata=0); core_rvalid in cycle 3 with rdata=0xDEADBEEF; dma_rvalid stays 0 throughout.
- Both ports hold req for 6 cycles after reset -> grant order core, dma, core, dma, core, dma; six responses on cycles 2-7, each routed to the correct port.
- DMA read at 0x06 -> dma_gnt same cycle; mem_MemRead=0 in the access cycle; dma_rvalid=1, dma_err=1, dma_rdata=0 two cycles later.
- Core write at 0x80 (DEPTH_WORDS=32) -> core_err=1 and no mem_MemWrite pulse; a subsequent read of 0x00 returns the prior contents unchanged.
- Core write 0x04=0x1234 accepted, rst_n pulled low during its access cycle -> mem_MemWrite drops immediately and no rvalid is issued. After reset release, a read of 0x04 returns the pre-write value.
- Core-only reads of 0x00, 0x04, 0x08, 0x0C on consecutive cycles (preloaded 1, 2, 3, 4) -> core_rvalid high for 4 consecutive cycles with rdata 1, 2, 3, 4.
